// File: rtl/gray_to_color_lut.sv
// Grey-to-RGB pseudocolour mapper, NUM_MAPS loadable tables; GRAY_TO_COLOR_INTERP_EN adds linear interpolation.
// Latency 2 (3 interpolated); whole pipeline stalls while m_valid & !m_ready, cfg writes never stall.
module gray_to_color_lut #(
  parameter int IN_W     = 8,
  parameter int OUT_W    = 8,
  parameter int IDX_W    = 8,
  parameter int NUM_MAPS = 4,
  parameter int SEL_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_W-1:0]      s_gray,
  input  logic [SEL_W-1:0]     s_map_sel,
  input  logic [1:0]           s_user,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_W-1:0]     m_r,
  output logic [OUT_W-1:0]     m_g,
  output logic [OUT_W-1:0]     m_b,
  output logic [1:0]           m_user,
  input  logic                 cfg_we,
  input  logic [SEL_W-1:0]     cfg_map,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [3*OUT_W-1:0]   cfg_rgb,
  output logic [31:0]          out_count
);
  localparam int RGB_W  = 3 * OUT_W;
  localparam int MAP_AW = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
  localparam int AW     = MAP_AW + IDX_W;
  localparam logic [SEL_W:0] MAPS = (SEL_W+1)'(NUM_MAPS);

  logic             ce;
  logic             s_hit;
  logic             wr_en;
  logic [IDX_W-1:0] s_idx;
  logic [OUT_W-1:0] s_scaled;
  logic [RGB_W-1:0] mem [2**AW];
  logic [RGB_W-1:0] rd_a;

  logic             fin_vld;
  logic [1:0]       fin_user;
  logic [RGB_W-1:0] fin_rgb;

  assign ce      = !m_valid || m_ready;
  assign s_ready = ce;
  assign s_idx   = s_gray[IN_W-1 -: IDX_W];
  assign s_hit   = {1'b0, s_map_sel} < MAPS;
  assign wr_en   = cfg_we && !rst && ({1'b0, cfg_map} < MAPS);

  generate
    if (IN_W >= OUT_W) begin : g_scale_trunc
      assign s_scaled = s_gray[IN_W-1 -: OUT_W];
    end else begin : g_scale_ext
      assign s_scaled = {{(OUT_W-IN_W){1'b0}}, s_gray};
    end
  endgenerate

`ifdef GRAY_TO_COLOR_INTERP_EN
  localparam int FR_W = IN_W - IDX_W;
  localparam int FRX  = (FR_W > 0) ? FR_W : 1;
  localparam int PW   = OUT_W + FRX + 2;

  logic [IDX_W-1:0] s_idx_n;
  logic [RGB_W-1:0] rd_b;
  logic [FRX-1:0]   s_frac;

  // upper neighbour saturates so the last entry interpolates onto itself
  assign s_idx_n = (s_idx == '1) ? s_idx : s_idx + IDX_W'(1);

  generate
    if (FR_W > 0) begin : g_frac
      assign s_frac = s_gray[FRX-1:0];
    end else begin : g_nofrac
      assign s_frac = '0;
    end
  endgenerate
`endif

  // read-first: a same-edge write is seen only by later reads
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{cfg_map[MAP_AW-1:0], cfg_addr}] <= cfg_rgb;
    end
    if (ce) begin
      rd_a <= mem[{s_map_sel[MAP_AW-1:0], s_idx}];
`ifdef GRAY_TO_COLOR_INTERP_EN
      rd_b <= mem[{s_map_sel[MAP_AW-1:0], s_idx_n}];
`endif
    end
  end

  logic             a_vld;
  logic             a_pass;
  logic [1:0]       a_user;
  logic [OUT_W-1:0] a_gray;
`ifdef GRAY_TO_COLOR_INTERP_EN
  logic [FRX-1:0]   a_frac;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld  <= 1'b0;
      a_pass <= 1'b0;
      a_user <= '0;
      a_gray <= '0;
`ifdef GRAY_TO_COLOR_INTERP_EN
      a_frac <= '0;
`endif
    end else if (ce) begin
      a_vld  <= s_valid;
      a_pass <= !s_hit;
      a_user <= s_user;
      a_gray <= s_scaled;
`ifdef GRAY_TO_COLOR_INTERP_EN
      a_frac <= s_frac;
`endif
    end
  end

`ifdef GRAY_TO_COLOR_INTERP_EN
  logic [2:0][OUT_W:0]  diff_c;
  logic [2:0][PW-1:0]   prod_c;
  logic                 b_vld;
  logic [1:0]           b_user;
  logic [RGB_W-1:0]     b_base;
  logic [2:0][PW-1:0]   b_prod;
  logic [RGB_W-1:0]     sum_c;
  logic                 c_vld;
  logic [1:0]           c_user;
  logic [RGB_W-1:0]     c_rgb;

  always_comb begin
    diff_c = '0;
    prod_c = '0;
    for (int ch = 0; ch < 3; ch++) begin
      diff_c[ch] = {1'b0, rd_b[ch*OUT_W +: OUT_W]} - {1'b0, rd_a[ch*OUT_W +: OUT_W]};
      prod_c[ch] = PW'($signed(diff_c[ch])) * PW'($signed({1'b0, a_frac}));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_vld  <= 1'b0;
      b_user <= '0;
      b_base <= '0;
      b_prod <= '0;
    end else if (ce) begin
      b_vld  <= a_vld;
      b_user <= a_user;
      b_base <= a_pass ? {3{a_gray}} : rd_a;
      b_prod <= a_pass ? '0 : prod_c;
    end
  end

  // |step| never exceeds |b-a|, so the sum stays inside [min(a,b), max(a,b)]
  always_comb begin
    sum_c = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum_c[ch*OUT_W +: OUT_W] = b_base[ch*OUT_W +: OUT_W]
                               + OUT_W'($signed(b_prod[ch]) >>> FR_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_vld  <= 1'b0;
      c_user <= '0;
      c_rgb  <= '0;
    end else if (ce) begin
      c_vld  <= b_vld;
      c_user <= b_user;
      c_rgb  <= sum_c;
    end
  end

  assign fin_vld  = c_vld;
  assign fin_user = c_user;
  assign fin_rgb  = c_rgb;
`else
  logic             b_vld;
  logic [1:0]       b_user;
  logic [RGB_W-1:0] b_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_vld  <= 1'b0;
      b_user <= '0;
      b_rgb  <= '0;
    end else if (ce) begin
      b_vld  <= a_vld;
      b_user <= a_user;
      b_rgb  <= a_pass ? {3{a_gray}} : rd_a;
    end
  end

  assign fin_vld  = b_vld;
  assign fin_user = b_user;
  assign fin_rgb  = b_rgb;
`endif

  // data regs load only with a valid pixel so bubbles never disturb the last output
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_r     <= '0;
      m_g     <= '0;
      m_b     <= '0;
      m_user  <= '0;
    end else if (ce) begin
      m_valid <= fin_vld;
      if (fin_vld) begin
        {m_r, m_g, m_b} <= fin_rgb;
        m_user          <= fin_user;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (m_valid && m_ready) begin
      out_count <= out_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_gray_to_color_lut.sv
// Directed bench for gray_to_color_lut: LUT lookup, passthrough, backpressure, collision, reset.
`timescale 1ns/1ps
module tb_gray_to_color_lut;
`ifdef GRAY_TO_COLOR_INTERP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, m_valid, m_ready, cfg_we;
  logic [7:0]  s_gray, m_r, m_g, m_b, cfg_addr;
  logic [2:0]  s_map_sel, cfg_map;
  logic [1:0]  s_user, m_user;
  logic [23:0] cfg_rgb;
  logic [31:0] out_count;

  always #5 clk = ~clk;

  gray_to_color_lut dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_gray(s_gray), .s_map_sel(s_map_sel), .s_user(s_user),
    .m_valid(m_valid), .m_ready(m_ready), .m_r(m_r), .m_g(m_g), .m_b(m_b), .m_user(m_user),
    .cfg_we(cfg_we), .cfg_map(cfg_map), .cfg_addr(cfg_addr), .cfg_rgb(cfg_rgb),
    .out_count(out_count)
  );

  typedef struct { logic [7:0] gray; logic [2:0] sel; logic [1:0] user; logic [23:0] rgb; } vec_t;
  typedef struct { logic [23:0] rgb; logic [1:0] user; int acc; } exp_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     ti;
  string  phase = "reset";
  exp_t   q[$];
  vec_t   tbl [NV];
  vec_t   jet [3];
  vec_t   idle, pv;
  logic   acc;
  logic   hold_prev = 1'b0;
  logic [25:0] held;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] map, input logic [7:0] addr, input logic [23:0] rgb);
    cfg_we = 1'b1; cfg_map = map; cfg_addr = addr; cfg_rgb = rgb;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One negedge-to-negedge cycle: drive, check what the coming edge hands off, record acceptance.
  task automatic step(input logic v, input vec_t p, input logic mr, input bit lat);
    exp_t e;
    s_valid = v; s_gray = p.gray; s_map_sel = p.sel; s_user = p.user; m_ready = mr;
    #1;
    chk("s_ready", 32'(s_ready), 32'(!m_valid || mr));
    if (hold_prev) chk("stable", 32'({m_user, m_r, m_g, m_b}), 32'(held));
    if (m_valid && mr) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s/spurious: got output 0x%0h, expected none", phase, {m_r, m_g, m_b});
      end else begin
        e = q.pop_front();
        chk("rgb", 32'({m_r, m_g, m_b}), 32'(e.rgb));
        chk("user", 32'(m_user), 32'(e.user));
        if (lat) chk("latency", 32'(cyc - e.acc), 32'(LAT + 1));
      end
    end
    acc = v && s_ready;
    if (acc) q.push_back('{p.rgb, p.user, cyc});
    hold_prev = m_valid && !mr;
    held = {m_user, m_r, m_g, m_b};
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int n, input bit lat);
    for (int i = 0; i < n; i++) step(1'b0, idle, 1'b1, lat);
    chk("drained", 32'(q.size()), 32'd0);
  endtask

`ifdef GRAY_TO_COLOR_INTERP_EN
  logic        i_s_valid, i_s_ready, i_m_valid, i_cfg_we;
  logic [9:0]  i_s_gray;
  logic [7:0]  i_m_r, i_m_g, i_m_b, i_cfg_addr;
  logic [1:0]  i_m_user;
  logic [23:0] i_cfg_rgb;
  logic [31:0] i_out_count;

  gray_to_color_lut #(.IN_W(10), .OUT_W(8), .IDX_W(8), .NUM_MAPS(4), .SEL_W(3)) dut_i (
    .clk(clk), .rst(rst),
    .s_valid(i_s_valid), .s_ready(i_s_ready), .s_gray(i_s_gray), .s_map_sel(3'd0), .s_user(2'b00),
    .m_valid(i_m_valid), .m_ready(1'b1), .m_r(i_m_r), .m_g(i_m_g), .m_b(i_m_b), .m_user(i_m_user),
    .cfg_we(i_cfg_we), .cfg_map(3'd0), .cfg_addr(i_cfg_addr), .cfg_rgb(i_cfg_rgb),
    .out_count(i_out_count)
  );

  task automatic run_interp();
    logic [7:0]  wa [5];
    logic [23:0] wd [5];
    logic [9:0]  gv [3];
    logic [23:0] ev [3];
    int n;
    wa[0] = 8'd20;  wd[0] = {8'd0,   8'd0,   8'd0};
    wa[1] = 8'd21;  wd[1] = {8'd100, 8'd200, 8'd40};
    wa[2] = 8'd30;  wd[2] = {8'd200, 8'd10,  8'd0};
    wa[3] = 8'd31;  wd[3] = {8'd100, 8'd10,  8'd255};
    wa[4] = 8'd255; wd[4] = 24'h123456;
    gv[0] = 10'd82;   ev[0] = {8'd50,  8'd100, 8'd20};
    gv[1] = 10'd123;  ev[1] = {8'd125, 8'd10,  8'd191};
    gv[2] = 10'd1023; ev[2] = 24'h123456;
    phase = "interp";
    for (int k = 0; k < 5; k++) begin
      i_cfg_we = 1'b1; i_cfg_addr = wa[k]; i_cfg_rgb = wd[k];
      @(negedge clk);
    end
    i_cfg_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_s_valid = 1'b1; i_s_gray = gv[k];
      @(negedge clk);
      i_s_valid = 1'b0;
      n = 1;
      while (!i_m_valid && n < 12) begin
        @(negedge clk);
        n++;
      end
      chk("i_latency", 32'(n), 32'(LAT + 1));
      chk("i_rgb", 32'({i_m_r, i_m_g, i_m_b}), 32'(ev[k]));
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle = '{8'd0, 3'd0, 2'b00, 24'd0};
    // map1 entry k holds (k, k+100, 200-k)
    tbl[0]  = '{8'd0,   3'd1, 2'b10, {8'd0,  8'd100, 8'd200}};
    tbl[1]  = '{8'd1,   3'd1, 2'b00, {8'd1,  8'd101, 8'd199}};
    tbl[2]  = '{8'd2,   3'd1, 2'b00, {8'd2,  8'd102, 8'd198}};
    tbl[3]  = '{8'd3,   3'd1, 2'b00, {8'd3,  8'd103, 8'd197}};
    tbl[4]  = '{8'd4,   3'd1, 2'b01, {8'd4,  8'd104, 8'd196}};
    tbl[5]  = '{8'd5,   3'd1, 2'b10, {8'd5,  8'd105, 8'd195}};
    tbl[6]  = '{8'd7,   3'd1, 2'b00, {8'd7,  8'd107, 8'd193}};
    tbl[7]  = '{8'd9,   3'd1, 2'b00, {8'd9,  8'd109, 8'd191}};
    tbl[8]  = '{8'd12,  3'd1, 2'b00, {8'd12, 8'd112, 8'd188}};
    tbl[9]  = '{8'd15,  3'd1, 2'b01, {8'd15, 8'd115, 8'd185}};
    tbl[10] = '{8'h5A,  3'd6, 2'b00, 24'h5A5A5A};
    tbl[11] = '{8'h11,  3'd4, 2'b00, 24'h111111};
    tbl[12] = '{8'hFF,  3'd3, 2'b11, 24'hABCDEF};
    tbl[13] = '{8'h00,  3'd0, 2'b00, 24'h000000};
    jet[0]  = '{8'd0,   3'd0, 2'b10, {8'd0,   8'd0,   8'd0}};
    jet[1]  = '{8'd128, 3'd0, 2'b00, {8'd0,   8'd255, 8'd255}};
    jet[2]  = '{8'd255, 3'd0, 2'b01, {8'd255, 8'd3,   8'd0}};

    rst = 1'b1; s_valid = 1'b0; s_gray = '0; s_map_sel = '0; s_user = '0; m_ready = 1'b0;
    cfg_we = 1'b0; cfg_map = '0; cfg_addr = '0; cfg_rgb = '0;
`ifdef GRAY_TO_COLOR_INTERP_EN
    i_s_valid = 1'b0; i_s_gray = '0; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_rgb = '0;
`endif
    repeat (3) @(negedge clk);
    chk("m_valid", 32'(m_valid), 32'd0);
    chk("rgb", 32'({m_r, m_g, m_b}), 32'd0);
    chk("m_user", 32'(m_user), 32'd0);
    chk("out_count", out_count, 32'd0);
    rst = 1'b0;

    wr(3'd0, 8'd0,   {8'd0,   8'd0,   8'd0});
    wr(3'd0, 8'd128, {8'd0,   8'd255, 8'd255});
    wr(3'd0, 8'd255, {8'd255, 8'd3,   8'd0});
    wr(3'd0, 8'd10,  {8'd1,   8'd2,   8'd3});
    for (int k = 0; k < 16; k++) wr(3'd1, 8'(k), {8'(k), 8'(k + 100), 8'(200 - k)});
    wr(3'd3, 8'd255, 24'hABCDEF);
    wr(3'd4, 8'd0,   24'h777777);

    phase = "jet";
    for (int k = 0; k < 3; k++) step(1'b1, jet[k], 1'b1, 1'b1);
    drain(6, 1'b1);
    chk("out_count", out_count, 32'd3);

    phase = "table";
    ti = 0;
    for (int c = 0; c < 80 && ti < NV; c++) begin
      step(1'b1, tbl[ti], !(c >= 4 && c < 9), 1'b0);
      if (acc) ti++;
    end
    chk("accepted", 32'(ti), 32'(NV));
    drain(8, 1'b0);
    chk("out_count", out_count, 32'd17);

    phase = "collision";
    cfg_we = 1'b1; cfg_map = 3'd0; cfg_addr = 8'd10; cfg_rgb = {8'd9, 8'd9, 8'd9};
    pv = '{8'd10, 3'd0, 2'b00, {8'd1, 8'd2, 8'd3}};
    step(1'b1, pv, 1'b1, 1'b1);
    cfg_we = 1'b0;
    pv = '{8'd10, 3'd0, 2'b00, {8'd9, 8'd9, 8'd9}};
    step(1'b1, pv, 1'b1, 1'b1);
    drain(6, 1'b1);
    chk("out_count", out_count, 32'd19);

    phase = "midreset";
    for (int k = 0; k < 3; k++) step(1'b1, tbl[k], 1'b0, 1'b0);
    chk("pre_vld", 32'(m_valid), 32'd1);
    s_valid = 1'b0; rst = 1'b1;
    cfg_we = 1'b1; cfg_map = 3'd1; cfg_addr = 8'd3; cfg_rgb = 24'hEEEEEE;
    repeat (2) @(negedge clk);
    rst = 1'b0; cfg_we = 1'b0;
    q.delete();
    hold_prev = 1'b0;
    chk("m_valid", 32'(m_valid), 32'd0);
    chk("rgb", 32'({m_r, m_g, m_b}), 32'd0);
    chk("out_count", out_count, 32'd0);
    chk("s_ready", 32'(s_ready), 32'd1);
    drain(6, 1'b0);
    step(1'b1, tbl[3], 1'b1, 1'b1);
    drain(6, 1'b1);
    chk("out_count", out_count, 32'd1);

`ifdef GRAY_TO_COLOR_INTERP_EN
    run_interp();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_to_color_lut.md
# gray_to_color_lut

Streaming pseudocolour mapper: converts a grey pixel stream into RGB using one of `NUM_MAPS` run-time-loadable colormap tables. It generalises the fixed-map grey-to-colour stage with parametrised input and output widths, programmable maps, optional interpolation, and valid/ready backpressure. It sits between the grey source (PGM reader or sensor path) and the RGB sink (PPM writer or display path).

## Interface
- `IN_W`, default 8: grey input width.
- `OUT_W`, default 8: width of each colour channel.
- `IDX_W`, default 8: LUT index width, where `IDX_W <= IN_W`; each map has 2^IDX_W entries.
- `NUM_MAPS`, default 4: number of colormap tables, 1 to 2^`SEL_W`.
- `SEL_W`, default 3: width of the map-select field.
- `clk` in 1: the only clock.
- `rst` in 1: reset; synchronous, active-high.
- `s_valid` in 1: input pixel valid.
- `s_ready` out 1: block can accept an input pixel.
- `s_gray` in `IN_W`: grey value.
- `s_map_sel` in `SEL_W`: map selection, taken per pixel.
- `s_user` in 2: sideband {sof, eol}, passed through unchanged.
- `m_valid` out 1: output pixel valid.
- `m_ready` in 1: downstream can accept the output pixel.
- `m_r`, `m_g`, `m_b` out `OUT_W` each: colour output.
- `m_user` out 2: delayed copy of `s_user`.
- `cfg_we` in 1: LUT write strobe.
- `cfg_map` in `SEL_W`: map to write.
- `cfg_addr` in `IDX_W`: entry index to write.
- `cfg_rgb` in 3*`OUT_W`: entry data as {R,G,B}.
- `out_count` out 32: count of output handshakes.

## Operation
- Pipeline enable: `ce = !m_valid | m_ready`, and `s_ready = ce`.
  - The whole pipeline stalls together; empty slots are not compacted.
- Accept: a pixel is taken on a clock edge where `s_valid & s_ready`.
  - `idx = s_gray[IN_W-1 -: IDX_W]`.
  - `frac = s_gray[IN_W-IDX_W-1:0]`; frac is empty when `IN_W == IDX_W`.
- LUT storage:
  - Synchronous read, issued on the accept edge.
  - Write takes effect when `cfg_we` is high on an edge.
  - A `cfg_map >= NUM_MAPS` write is ignored.
- Read/write collision: a same-edge read and write to the same map/entry returns the old data (read-first).
  - The new data is visible to pixels accepted on any later edge.
- Passthrough map select: if `s_map_sel >= NUM_MAPS`, all three channels output `s_gray` scaled to `OUT_W`.
  - Scaling keeps the top `OUT_W` bits of `s_gray`, zero-extended if `IN_W < OUT_W`.
- Reset:
  - `m_valid=0`, `m_r=m_g=m_b=0`, `m_user=0`, `out_count=0`.
  - All internal valid bits are cleared.
  - LUT contents are **not** reset.
  - `cfg_we` is ignored while `rst` is high.
  - A reset mid-stream drops all in-flight pixels; no partial output appears.
- `out_count` increments on each edge where `m_valid & m_ready`.
  - It wraps from 0xFFFFFFFF to 0.
  - It is held while `rst` is high.
- Ordering: pixels and `s_user` leave in acceptance order; there is no loss or duplication under any `m_ready` pattern.

## Timing
- Latency without interpolation: 2 cycles. A pixel accepted on edge N appears with `m_valid=1` after edge N+2, provided `ce` stays high.
- Latency with `GRAY_TO_COLOR_INTERP_EN`: 3 cycles.
- Each cycle of stall (`ce=0`) adds one cycle of latency.
- While stalled, the outputs and all stage registers hold; RAM reads are gated by `ce`.
- Throughput: 1 pixel per clock when `m_ready` is held high.
- `m_*` data is stable while `m_valid & !m_ready`.
- `cfg_*` is never backpressured; one write completes every cycle, independent of `ce`.

## Configuration
- `GRAY_TO_COLOR_INTERP_EN` defined:
  - Read entries `idx` and `idx+1`; `idx+1` saturates at 2^`IDX_W`-1.
  - Per channel: `out = a + (((b - a) * frac) >>> (IN_W-IDX_W))`, using signed `OUT_W+1` bit differences.
  - No clamp is needed.
  - Adds one multiply stage, making latency 3.
- `GRAY_TO_COLOR_INTERP_EN` undefined:
  - Nearest-lower lookup from entry `idx` only; `frac` is ignored.
  - Single read port per map; latency 2.
- Passthrough map select is the same in both builds.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-stream.
  - Next cycle: `m_valid=0`, RGB=0, `out_count=0`, `s_ready=1`.
  - No pre-reset pixel ever appears.
- **JET lookup:** load map 0 with the JET table, then stream 0, 128, 255 with `m_ready=1`.
  - Outputs are (0,0,0), (0,255,255), (255,3,0).
  - Each appears 2 cycles after acceptance; `out_count=3`.
- **Backpressure:** stream 10 pixels and drop `m_ready` for 5 cycles in the middle.
  - Outputs are the exact 10 in order.
  - `s_ready=0` while `m_valid & !m_ready`.
  - `m_user` sof/eol stays aligned with its pixels.
- **Passthrough:** `s_map_sel=6`, `NUM_MAPS=4`, gray=0x5A.
  - Output is (0x5A,0x5A,0x5A).
- **Collision:** map 0, entry 10 = (1,2,3).
  - On the same edge, write (9,9,9) to entry 10 and accept gray=10; the output is (1,2,3).
  - The next gray=10 gives (9,9,9).
- **Interpolation:** `GRAY_TO_COLOR_INTERP_EN`, `IN_W=10`, `IDX_W=8`.
  - Entry 20=(0,0,0), entry 21=(100,200,40); gray=82 gives (50,100,20).
  - gray=1023 gives entry 255 exactly.
